// File: rtl/gps_code_correlator.sv
// Early/punctual/late accumulate-and-dump correlator: six saturating I/Q sums
// integrated over INT_EPOCHS code periods, presented through a valid/ready dump register.
module gps_code_correlator #(
  parameter int SAMPLE_W   = 4,
  parameter int ACC_W      = 24,
  parameter int CNT_W      = 16,
  parameter int INT_EPOCHS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic [SAMPLE_W-1:0] q_sample,
  input  logic                ca_code_e,
  input  logic                ca_code_p,
  input  logic                ca_code_l,
  input  logic                code_epoch,
  output logic [ACC_W-1:0]    ie,
  output logic [ACC_W-1:0]    qe,
  output logic [ACC_W-1:0]    ip,
  output logic [ACC_W-1:0]    qp,
  output logic [ACC_W-1:0]    il,
  output logic [ACC_W-1:0]    ql,
  output logic [CNT_W-1:0]    sample_count,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic                overrun
);
  localparam int NCH  = 6;
  localparam int EP_W = 5;
  localparam logic [EP_W-1:0] EP_LAST = EP_W'(INT_EPOCHS);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                    state_q, state_d;
  logic [NCH-1:0][ACC_W-1:0] acc_q, acc_d, sums_q, sums_d, contrib;
  logic [CNT_W-1:0]          cnt_q, cnt_d, dcnt_q, dcnt_d;
  logic [EP_W-1:0]           ep_q, ep_d;
  logic                      dv_q, dv_d, ovr_q, ovr_d;
  logic                      close;
  logic [2:0]                chip;

  assign chip = {ca_code_l, ca_code_p, ca_code_e};

  // Channel order: ie, qe, ip, qp, il, ql. Chip 1 negates the sample.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [SAMPLE_W-1:0] smp;
    logic [ACC_W-1:0]    ext;
    assign smp        = (c % 2 == 0) ? i_sample : q_sample;
    assign ext        = {{(ACC_W-SAMPLE_W){smp[SAMPLE_W-1]}}, smp};
    assign contrib[c] = chip[c/2] ? -ext : ext;
  end

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1])
      sat_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sat_add = s[ACC_W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ep_d    = ep_q;
    sums_d  = sums_q;
    dcnt_d  = dcnt_q;
    dv_d    = dv_q;
    ovr_d   = ovr_q;
    close   = 1'b0;
    if (dv_q && dump_ready) dv_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ep_d    = '0;
    end else if (sample_valid) begin
      if (state_q == IDLE) begin
        if (code_epoch) begin
          state_d = ACCUM;
          acc_d   = contrib;
          cnt_d   = CNT_W'(1);
          ep_d    = EP_W'(1);
        end
      end else if (code_epoch && ep_q == EP_LAST) begin
        // Closing sample belongs to the next integration, not this dump.
        close = 1'b1;
        acc_d = contrib;
        cnt_d = CNT_W'(1);
        ep_d  = EP_W'(1);
      end else begin
        if (code_epoch) ep_d = ep_q + EP_W'(1);
        for (int c = 0; c < NCH; c++) acc_d[c] = sat_add(acc_q[c], contrib[c]);
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      end
    end
    if (close) begin
      if (!dv_q || dump_ready) begin
        sums_d = acc_q;
        dcnt_d = cnt_q;
        dv_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ep_q    <= '0;
      sums_q  <= '0;
      dcnt_q  <= '0;
      dv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ep_q    <= ep_d;
      sums_q  <= sums_d;
      dcnt_q  <= dcnt_d;
      dv_q    <= dv_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ie           = sums_q[0];
  assign qe           = sums_q[1];
  assign ip           = sums_q[2];
  assign qp           = sums_q[3];
  assign il           = sums_q[4];
  assign ql           = sums_q[5];
  assign sample_count = dcnt_q;
  assign dump_valid   = dv_q;
  assign overrun      = ovr_q;
endmodule

// File: tb/tb_gps_code_correlator.sv
// Bench for gps_code_correlator: DUT A (24-bit, 1 epoch) and DUT B (8-bit, 2 epochs) share stimulus.
module tb_gps_code_correlator;
  localparam int SW = 4;
  localparam int NV = 240;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, sample_valid = 1'b0;
  logic ca_e = 1'b0, ca_p = 1'b0, ca_l = 1'b0, code_epoch = 1'b0, dump_ready = 1'b0;
  logic [SW-1:0] i_s = '0, q_s = '0;
  logic signed [23:0] a_ie, a_qe, a_ip, a_qp, a_il, a_ql;
  logic signed [7:0]  b_ie, b_qe, b_ip, b_qp, b_il, b_ql;
  logic [15:0] a_cnt, b_cnt;
  logic a_dv, a_ovr, b_dv, b_ovr;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  gps_code_correlator #(.SAMPLE_W(4), .ACC_W(24), .CNT_W(16), .INT_EPOCHS(1)) u_a (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .i_sample(i_s), .q_sample(q_s), .ca_code_e(ca_e), .ca_code_p(ca_p), .ca_code_l(ca_l),
    .code_epoch(code_epoch), .ie(a_ie), .qe(a_qe), .ip(a_ip), .qp(a_qp), .il(a_il), .ql(a_ql),
    .sample_count(a_cnt), .dump_valid(a_dv), .dump_ready(dump_ready), .overrun(a_ovr));

  gps_code_correlator #(.SAMPLE_W(4), .ACC_W(8), .CNT_W(16), .INT_EPOCHS(2)) u_b (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .i_sample(i_s), .q_sample(q_s), .ca_code_e(ca_e), .ca_code_p(ca_p), .ca_code_l(ca_l),
    .code_epoch(code_epoch), .ie(b_ie), .qe(b_qe), .ip(b_ip), .qp(b_qp), .il(b_il), .ql(b_ql),
    .sample_count(b_cnt), .dump_valid(b_dv), .dump_ready(dump_ready), .overrun(b_ovr));

  function automatic logic [143:0] pa(input int a, input int b, input int c, input int d, input int e, input int f);
    return {24'(a), 24'(b), 24'(c), 24'(d), 24'(e), 24'(f)};
  endfunction

  function automatic logic [47:0] pb(input int a, input int b, input int c, input int d, input int e, input int f);
    return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f)};
  endfunction

  task automatic step(input bit v, input int i, input int q, input bit e, input bit p, input bit l, input bit ep);
    sample_valid = v;
    i_s = i[SW-1:0];
    q_s = q[SW-1:0];
    ca_e = e; ca_p = p; ca_l = l;
    code_epoch = ep;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; dump_ready = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0; enable = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_ie, a_qe, a_ip, a_qp, a_il, a_ql} !== 144'd0) begin
      errors++; $display("FAIL reset_a_sums got %0h want 0", {a_ie, a_qe, a_ip, a_qp, a_il, a_ql});
    end
    checks++;
    if ({a_cnt, a_dv, a_ovr} !== 18'd0) begin
      errors++; $display("FAIL reset_a_ctl got %0h want 0", {a_cnt, a_dv, a_ovr});
    end
    checks++;
    if ({b_ie, b_qe, b_ip, b_qp, b_il, b_ql} !== 48'd0) begin
      errors++; $display("FAIL reset_b_sums got %0h want 0", {b_ie, b_qe, b_ip, b_qp, b_il, b_ql});
    end
    checks++;
    if ({b_cnt, b_dv, b_ovr} !== 18'd0) begin
      errors++; $display("FAIL reset_b_ctl got %0h want 0", {b_cnt, b_dv, b_ovr});
    end
  endtask

  task automatic test_basic();
    do_reset();
    for (int n = 0; n <= 10; n++) begin
      if (n == 10) begin
        checks++;
        if (a_dv !== 1'b0) begin errors++; $display("FAIL basic_dv_early got %0b want 0", a_dv); end
      end
      step(1, 3, -2, 0, 0, 0, n % 10 == 0);
    end
    checks++;
    if (a_dv !== 1'b1) begin errors++; $display("FAIL basic_dv got %0b want 1", a_dv); end
    checks++;
    if ({a_ie, a_qe, a_ip, a_qp, a_il, a_ql} !== pa(30, -20, 30, -20, 30, -20)) begin
      errors++; $display("FAIL basic_sums got %0h want %0h", {a_ie, a_qe, a_ip, a_qp, a_il, a_ql}, pa(30, -20, 30, -20, 30, -20));
    end
    checks++;
    if (a_cnt !== 16'd10) begin errors++; $display("FAIL basic_count got %0d want 10", a_cnt); end
  endtask

  task automatic test_codes();
    do_reset();
    for (int n = 0; n <= 10; n++) step(1, 3, -2, 0, 1, n % 2 == 1, n % 10 == 0);
    checks++;
    if ({a_ie, a_qe, a_ip, a_qp, a_il, a_ql} !== pa(30, -20, -30, 20, 0, 0)) begin
      errors++; $display("FAIL codes_sums got %0h want %0h", {a_ie, a_qe, a_ip, a_qp, a_il, a_ql}, pa(30, -20, -30, 20, 0, 0));
    end
  endtask

  task automatic test_multi_epoch();
    do_reset();
    for (int n = 0; n <= 10; n++) step(1, 1, 0, 0, 0, 0, n % 5 == 0);
    checks++;
    if ({b_dv, b_cnt} !== {1'b1, 16'd10}) begin errors++; $display("FAIL multi_first_ctl got %0h want %0h", {b_dv, b_cnt}, {1'b1, 16'd10}); end
    checks++;
    if ({b_ie, b_qe, b_ip, b_qp, b_il, b_ql} !== pb(10, 0, 10, 0, 10, 0)) begin
      errors++; $display("FAIL multi_first_sums got %0h want %0h", {b_ie, b_qe, b_ip, b_qp, b_il, b_ql}, pb(10, 0, 10, 0, 10, 0));
    end
    dump_ready = 1'b1;
    step(1, 1, 0, 0, 0, 0, 0);
    dump_ready = 1'b0;
    checks++;
    if (b_dv !== 1'b0) begin errors++; $display("FAIL multi_accept got %0b want 0", b_dv); end
    for (int n = 12; n <= 20; n++) step(1, 1, 0, 0, 0, 0, n % 5 == 0);
    checks++;
    if ({b_dv, b_cnt, b_ip} !== {1'b1, 16'd10, 8'd10}) begin
      errors++; $display("FAIL multi_second got %0h want %0h", {b_dv, b_cnt, b_ip}, {1'b1, 16'd10, 8'd10});
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int n = 0; n <= 80; n++) begin
      step(1, 7, -8, 1, 0, 0, n % 40 == 0);
      if (n == 40) begin
        checks++;
        if ({a_ie, a_qe, a_ip, a_qp, a_il, a_ql, a_cnt} !== {pa(-280, 320, 280, -320, 280, -320), 16'd40}) begin
          errors++; $display("FAIL sat_wide got %0h want %0h", {a_ie, a_qe, a_ip, a_qp, a_il, a_ql, a_cnt}, {pa(-280, 320, 280, -320, 280, -320), 16'd40});
        end
      end
    end
    checks++;
    if ({b_ie, b_qe, b_ip, b_qp, b_il, b_ql} !== pb(-128, 127, 127, -128, 127, -128)) begin
      errors++; $display("FAIL sat_narrow got %0h want %0h", {b_ie, b_qe, b_ip, b_qp, b_il, b_ql}, pb(-128, 127, 127, -128, 127, -128));
    end
    checks++;
    if ({b_dv, b_cnt} !== {1'b1, 16'd80}) begin errors++; $display("FAIL sat_count got %0h want %0h", {b_dv, b_cnt}, {1'b1, 16'd80}); end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int n = 0; n <= 16; n++) begin
      dump_ready = (n == 16);
      step(1, n / 4 + 1, 0, 0, 0, 0, n % 4 == 0);
      if (n == 4) begin
        checks++;
        if ({a_dv, a_ovr, a_ip} !== {2'b10, 24'd4}) begin errors++; $display("FAIL ovr_first got %0h want %0h", {a_dv, a_ovr, a_ip}, {2'b10, 24'd4}); end
      end
      if (n == 8) begin
        checks++;
        if ({a_dv, a_ovr, a_ip} !== {2'b11, 24'd4}) begin errors++; $display("FAIL ovr_drop got %0h want %0h", {a_dv, a_ovr, a_ip}, {2'b11, 24'd4}); end
        dump_ready = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({a_dv, a_ovr} !== 2'b01) begin errors++; $display("FAIL ovr_accept got %0b want 01", {a_dv, a_ovr}); end
      end
      if (n == 12) begin
        checks++;
        if ({a_dv, a_ip} !== {1'b1, 24'd12}) begin errors++; $display("FAIL ovr_reload got %0h want %0h", {a_dv, a_ip}, {1'b1, 24'd12}); end
      end
    end
    checks++;
    if ({a_dv, a_ip, a_cnt} !== {1'b1, 24'd16, 16'd4}) begin
      errors++; $display("FAIL b2b_close_accept got %0h want %0h", {a_dv, a_ip, a_cnt}, {1'b1, 24'd16, 16'd4});
    end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({a_dv, a_ovr} !== 2'b01) begin errors++; $display("FAIL ovr_sticky got %0b want 01", {a_dv, a_ovr}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int n = 0; n <= 23; n++) step(1, 2, 1, 0, 0, 0, n % 10 == 0);
    rst = 1'b1;
    #1;
    checks++;
    if ({a_ie, a_qe, a_ip, a_qp, a_il, a_ql, a_cnt, a_dv, a_ovr} !== '0) begin
      errors++; $display("FAIL rstmid_clear got %0h want 0", {a_ie, a_qe, a_ip, a_qp, a_il, a_ql, a_cnt, a_dv, a_ovr});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n <= 10; n++) begin
      if (n == 10) begin
        checks++;
        if (a_dv !== 1'b0) begin errors++; $display("FAIL rstmid_early got %0b want 0", a_dv); end
      end
      step(1, 2, 1, 0, 0, 0, n % 10 == 0);
    end
    checks++;
    if ({a_dv, a_cnt, a_ip, a_qp} !== {1'b1, 16'd10, 24'd20, 24'd10}) begin
      errors++; $display("FAIL rstmid_dump got %0h want %0h", {a_dv, a_cnt, a_ip, a_qp}, {1'b1, 16'd10, 24'd20, 24'd10});
    end
  endtask

  task automatic test_enable();
    for (int n = 11; n <= 13; n++) step(1, 2, 1, 0, 0, 0, 0);
    enable = 1'b0;
    step(1, 2, 1, 0, 0, 0, 0);
    checks++;
    if ({a_dv, a_cnt, a_ip} !== {1'b1, 16'd10, 24'd20}) begin
      errors++; $display("FAIL enable_hold got %0h want %0h", {a_dv, a_cnt, a_ip}, {1'b1, 16'd10, 24'd20});
    end
    enable = 1'b1;
    for (int n = 0; n < 3; n++) step(1, 2, 1, 0, 0, 0, 0);
    dump_ready = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    dump_ready = 1'b0;
    for (int n = 0; n <= 5; n++) step(1, 2, 1, 0, 0, 0, n % 5 == 0);
    checks++;
    if ({a_dv, a_cnt, a_ip} !== {1'b1, 16'd5, 24'd10}) begin
      errors++; $display("FAIL enable_restart got %0h want %0h", {a_dv, a_cnt, a_ip}, {1'b1, 16'd5, 24'd10});
    end
  endtask

  task automatic test_random();
    int si[NV], sq[NV];
    bit chip[NV][3];
    bit isep[NV];
    int ep_idx[$];
    logic [143:0] qa[$];
    logic [47:0]  qb[$];
    int ca[$], cb[$];
    int nxt, idx, guard;
    nxt = 0;
    for (int n = 0; n < NV; n++) begin
      si[n] = int'($urandom_range(0, 15)) - 8;
      sq[n] = int'($urandom_range(0, 15)) - 8;
      for (int k = 0; k < 3; k++) chip[n][k] = $urandom_range(0, 1) == 1;
      isep[n] = (n == nxt);
      if (n == nxt) begin ep_idx.push_back(n); nxt = n + int'($urandom_range(3, 12)); end
    end
    // Integration k spans the samples from epoch k*N up to (not including) epoch (k+1)*N.
    for (int d = 0; d < 2; d++) begin
      int n_ep, lo, hi;
      n_ep = (d == 0) ? 1 : 2;
      lo = (d == 0) ? -(1 << 23) : -128;
      hi = (d == 0) ? (1 << 23) - 1 : 127;
      for (int k = 0; (k + 1) * n_ep < ep_idx.size(); k++) begin
        int st, sp;
        int s[6];
        st = ep_idx[k * n_ep];
        sp = ep_idx[(k + 1) * n_ep];
        for (int ch = 0; ch < 6; ch++) begin
          s[ch] = 0;
          for (int j = st; j < sp; j++) begin
            int v;
            v = (ch % 2 == 0) ? si[j] : sq[j];
            s[ch] += chip[j][ch / 2] ? -v : v;
            if (s[ch] > hi) s[ch] = hi;
            if (s[ch] < lo) s[ch] = lo;
          end
        end
        if (d == 0) begin qa.push_back(pa(s[0], s[1], s[2], s[3], s[4], s[5])); ca.push_back(sp - st); end
        else        begin qb.push_back(pb(s[0], s[1], s[2], s[3], s[4], s[5])); cb.push_back(sp - st); end
      end
    end
    do_reset();
    dump_ready = 1'b1;
    idx = 0;
    guard = 0;
    while (idx < NV && guard < 4000) begin
      guard++;
      if ($urandom_range(0, 3) == 0)
        step(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1, 1'b0, 1'b1, 1'b0);
      else begin
        step(1, si[idx], sq[idx], chip[idx][0], chip[idx][1], chip[idx][2], isep[idx]);
        idx++;
      end
      if (a_dv === 1'b1) begin
        checks++;
        if (qa.size() == 0) begin errors++; $display("FAIL rand_a_extra got dump want none"); end
        else begin
          logic [143:0] e;
          int c;
          e = qa.pop_front();
          c = ca.pop_front();
          if ({a_ie, a_qe, a_ip, a_qp, a_il, a_ql} !== e || a_cnt !== 16'(c)) begin
            errors++; $display("FAIL rand_a_dump got %0h/%0d want %0h/%0d", {a_ie, a_qe, a_ip, a_qp, a_il, a_ql}, a_cnt, e, c);
          end
        end
      end
      if (b_dv === 1'b1) begin
        checks++;
        if (qb.size() == 0) begin errors++; $display("FAIL rand_b_extra got dump want none"); end
        else begin
          logic [47:0] e;
          int c;
          e = qb.pop_front();
          c = cb.pop_front();
          if ({b_ie, b_qe, b_ip, b_qp, b_il, b_ql} !== e || b_cnt !== 16'(c)) begin
            errors++; $display("FAIL rand_b_dump got %0h/%0d want %0h/%0d", {b_ie, b_qe, b_ip, b_qp, b_il, b_ql}, b_cnt, e, c);
          end
        end
      end
    end
    checks++;
    if (qa.size() != 0 || qb.size() != 0 || idx != NV) begin
      errors++; $display("FAIL rand_missing got %0d/%0d pending want 0/0", qa.size(), qb.size());
    end
    checks++;
    if ({a_ovr, b_ovr} !== 2'b00) begin errors++; $display("FAIL rand_overrun got %0b want 00", {a_ovr, b_ovr}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_codes();
    test_multi_epoch();
    test_saturation();
    test_overrun();
    test_reset_mid();
    test_enable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
